lb_arbiter: RTL and testbench

- Shares one local bus (24-bit address, 32-bit data, fixed read latency) between N_REQ independent masters, e.g. the network mem gateway, a soft-CPU bridge and a DRP sequencer.
- Round-robin grant; at most one transaction is issued per cycle.
- Read tags are tracked through a fixed-latency pipeline, so each read return is steered to the requester that issued it.
- Sits between the masters and the existing lb_* slave decode.

---
 rtl/lb_pkg.sv | 12 +
 rtl/rr_pick.sv | 35 +++
 rtl/lb_arbiter.sv | 89 ++++++++
 tb/tb_lb_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lb_pkg.sv
// rtl/lb_pkg.sv - shared local-bus widths and read-tag type
package lb_pkg;
   localparam int LB_AW  = 24;
   localparam int LB_DW  = 32;
   // Tag id is sized for the largest supported requester count (8)
   localparam int LB_IDW = 3;

   typedef struct packed {
      logic              valid;
      logic [LB_IDW-1:0] id;
   } lb_tag_t;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, first active req at or after ptr
module rr_pick #(
   parameter int N   = 3,
   parameter int IDW = 3
) (
   input  logic [N-1:0]   req_i,
   input  logic [IDW-1:0] ptr_i,
   output logic [N-1:0]   gnt_o,
   output logic [IDW-1:0] id_o,
   output logic           any_o
);
   int   start;
   int   idx;
   logic found;

   always_comb begin
      gnt_o = '0;
      id_o  = '0;
      found = 1'b0;
      idx   = 0;
      // An out-of-range pointer restarts the search at index 0
      start = (int'(ptr_i) < N) ? int'(ptr_i) : 0;
      for (int off = 0; off < N; off++) begin
         idx = start + off;
         if (idx >= N) idx = idx - N;
         if (!found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            id_o       = IDW'(idx);
            found      = 1'b1;
         end
      end
   end

   assign any_o = |req_i;
endmodule

// File: rtl/lb_arbiter.sv
// rtl/lb_arbiter.sv - round-robin local-bus arbiter with fixed-latency read return steering
module lb_arbiter import lb_pkg::*; #(
   parameter int N_REQ    = 3,
   parameter int READ_LAT = 3,
   parameter int IDW      = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ-1:0]       req_we,
   input  logic [LB_AW*N_REQ-1:0] req_addr,
   input  logic [LB_DW*N_REQ-1:0] req_wdata,
   output logic [N_REQ-1:0]       gnt,
   output logic [N_REQ-1:0]       rd_valid,
   output logic [LB_DW-1:0]       rd_data,
   output logic [LB_AW-1:0]       lb_addr,
   output logic                   lb_write,
   output logic                   lb_read,
   output logic [LB_DW-1:0]       lb_wdata,
   input  logic [LB_DW-1:0]       lb_rdata
);
   logic [N_REQ-1:0] pick_gnt;
   logic [IDW-1:0]   pick_id;
   logic             pick_any;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]   gid_q;
   logic [LB_AW-1:0] lb_addr_q;
   logic [LB_DW-1:0] lb_wdata_q;
   logic             lb_write_q, lb_read_q;
   lb_tag_t          tag_q [READ_LAT];
   lb_tag_t          tag_exit;
   logic [N_REQ-1:0] rd_onehot;
   logic [N_REQ-1:0] rd_valid_q;
   logic [LB_DW-1:0] rd_data_q;

   rr_pick #(.N(N_REQ), .IDW(IDW)) u_pick (
      .req_i (req),
      .ptr_i (rr_ptr_q),
      .gnt_o (pick_gnt),
      .id_o  (pick_id),
      .any_o (pick_any)
   );

   assign gnt = rst ? '0 : pick_gnt;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (pick_any)
         rr_ptr_d = (int'(pick_id) == N_REQ - 1) ? '0 : pick_id + 1'b1;
   end

   assign tag_exit  = tag_q[READ_LAT-1];
   assign rd_onehot = N_REQ'(1) << tag_exit.id;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q   <= '0;
         gid_q      <= '0;
         lb_addr_q  <= '0;
         lb_wdata_q <= '0;
         lb_write_q <= 1'b0;
         lb_read_q  <= 1'b0;
         for (int i = 0; i < READ_LAT; i++) tag_q[i] <= '0;
         rd_valid_q <= '0;
         rd_data_q  <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         lb_write_q <= pick_any &  req_we[pick_id];
         lb_read_q  <= pick_any & ~req_we[pick_id];
         if (pick_any) begin
            lb_addr_q  <= req_addr[int'(pick_id)*LB_AW +: LB_AW];
            lb_wdata_q <= req_wdata[int'(pick_id)*LB_DW +: LB_DW];
            gid_q      <= pick_id;
         end
         // Tag enters alongside the read strobe, exits when the slave data is valid
         tag_q[0] <= '{valid: lb_read_q, id: LB_IDW'(gid_q)};
         for (int i = 1; i < READ_LAT; i++) tag_q[i] <= tag_q[i-1];
         rd_valid_q <= tag_exit.valid ? rd_onehot : '0;
         if (tag_exit.valid) rd_data_q <= lb_rdata;
      end
   end

   assign lb_addr  = lb_addr_q;
   assign lb_wdata = lb_wdata_q;
   assign lb_write = lb_write_q;
   assign lb_read  = lb_read_q;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
endmodule

// File: tb/tb_lb_arbiter.sv
// tb/tb_lb_arbiter.sv - self-checking bench for lb_arbiter
module tb_lb_arbiter;
   localparam int N  = 3;
   localparam int RL = 3;

   localparam int F_GNT = 0, F_LBR = 1, F_LBW = 2, F_ADDR = 3, F_WD = 4, F_RDV = 5, F_RDD = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req, req_we;
   logic [71:0]   req_addr;
   logic [95:0]   req_wdata;
   logic [N-1:0]  gnt, rd_valid;
   logic [31:0]   rd_data, lb_wdata;
   logic [23:0]   lb_addr;
   logic          lb_write, lb_read;
   logic [31:0]   lb_rdata = 32'h0;

   always #5 clk = ~clk;

   lb_arbiter #(.N_REQ(N), .READ_LAT(RL), .IDW(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .gnt       (gnt),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .lb_addr   (lb_addr),
      .lb_write  (lb_write),
      .lb_read   (lb_read),
      .lb_wdata  (lb_wdata),
      .lb_rdata  (lb_rdata)
   );

   typedef struct { int due; int id; } pend_t;
   typedef struct { int c; int f; logic [31:0] v; } lit_t;

   int          cyc = 0;
   int          m_ptr = 0;
   int          k;
   int          k2;
   logic [2:0]  eg;
   logic [2:0]  e_rdv = '0;
   logic [31:0] e_rdd = '0, e_wd = '0;
   logic [23:0] e_addr = '0;
   logic        e_w = 1'b0, e_r = 1'b0;
   pend_t       pend[$];
   logic [31:0] s_data [256];
   bit          s_vld  [256];
   lit_t        lit_tab [128];
   int          lit_n = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   string       fname [7] = '{"gnt", "lb_read", "lb_write", "lb_addr", "lb_wdata", "rd_valid", "rd_data"};

   function automatic int pick(logic [2:0] r, int p);
      for (int off = 0; off < N; off++)
         if (r[(p + off) % N]) return (p + off) % N;
      return -1;
   endfunction

   function automatic logic [31:0] rdata_of(logic [23:0] a);
      return (a == 24'h000123) ? 32'hDEADBEEF : {8'hC0, a};
   endfunction

   function automatic logic [31:0] act_of(int f);
      case (f)
         F_GNT:   return 32'(gnt);
         F_LBR:   return 32'(lb_read);
         F_LBW:   return 32'(lb_write);
         F_ADDR:  return 32'(lb_addr);
         F_WD:    return lb_wdata;
         F_RDV:   return 32'(rd_valid);
         default: return rd_data;
      endcase
   endfunction

   // Model plus slave: reads complete RL cycles after the strobe, returns in issue order
   always @(posedge clk) begin
      if (rst) begin
         m_ptr = 0; e_rdv = '0; e_rdd = '0; e_wd = '0; e_addr = '0; e_w = 1'b0; e_r = 1'b0;
         pend.delete();
      end else begin
         e_rdv = '0;
         if (pend.size() > 0 && pend[0].due == cyc) begin
            e_rdv = 3'(1 << pend[0].id);
            e_rdd = lb_rdata;
            void'(pend.pop_front());
         end
         k = pick(req, m_ptr);
         if (k >= 0) begin
            e_addr = req_addr[k*24 +: 24];
            e_wd   = req_wdata[k*32 +: 32];
            e_w    = req_we[k];
            e_r    = !req_we[k];
            if (!req_we[k]) pend.push_back('{cyc + 1 + RL, k});
            m_ptr = (k + 1) % N;
         end else begin
            e_w = 1'b0;
            e_r = 1'b0;
         end
      end
      if (lb_read) begin
         s_data[(cyc + RL) % 256] = rdata_of(lb_addr);
         s_vld[(cyc + RL) % 256]  = 1'b1;
      end
      cyc++;
      #1;
      lb_rdata = s_vld[cyc % 256] ? s_data[cyc % 256] : (32'h0BAD0000 | 32'(cyc));
      s_vld[cyc % 256] = 1'b0;
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_gnt", 32'(gnt), 32'h0);
         chk("rst_rd_valid", 32'(rd_valid), 32'h0);
         chk("rst_rd_data", rd_data, 32'h0);
         chk("rst_lb_addr", 32'(lb_addr), 32'h0);
         chk("rst_lb_wdata", lb_wdata, 32'h0);
         chk("rst_strobes", {30'h0, lb_read, lb_write}, 32'h0);
      end else begin
         k2 = pick(req, m_ptr);
         eg = (k2 >= 0) ? 3'(1 << k2) : 3'b000;
         chk("gnt", 32'(gnt), 32'(eg));
         chk("lb_read", 32'(lb_read), 32'(e_r));
         chk("lb_write", 32'(lb_write), 32'(e_w));
         chk("lb_addr", 32'(lb_addr), 32'(e_addr));
         chk("lb_wdata", lb_wdata, e_wd);
         chk("rd_valid", 32'(rd_valid), 32'(e_rdv));
         chk("rd_data", rd_data, e_rdd);
         chk("rw_exclusive", 32'(lb_read & lb_write), 32'h0);
         for (int i = 0; i < lit_n; i++)
            if (lit_tab[i].c == cyc)
               chk({"pin_", fname[lit_tab[i].f]}, act_of(lit_tab[i].f), lit_tab[i].v);
      end
   end

   task automatic pin(int off, int f, logic [31:0] v);
      lit_tab[lit_n] = '{cyc + off, f, v};
      lit_n++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [2:0] fair_seq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

   initial begin
      rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      step();

      // Fairness: all three read every cycle for six cycles
      req_addr  = {24'h000300, 24'h000200, 24'h000100};
      req_wdata = {32'h33333333, 32'h22222222, 32'h11111111};
      for (int i = 0; i < 6; i++) begin
         pin(i, F_GNT, 32'(fair_seq[i]));
         pin(i + 5, F_RDV, 32'(fair_seq[i]));
      end
      pin(5, F_RDD, 32'hC0000100);
      pin(6, F_RDD, 32'hC0000200);
      pin(7, F_RDD, 32'hC0000300);
      req = 3'b111;
      repeat (6) step();
      req = '0;
      repeat (8) step();

      // Single read from requester 1
      req_addr = {24'h0, 24'h000123, 24'h0};
      pin(0, F_GNT, 32'h2); pin(1, F_LBR, 32'h1); pin(1, F_ADDR, 32'h000123);
      pin(5, F_RDV, 32'h2); pin(5, F_RDD, 32'hDEADBEEF); pin(6, F_RDV, 32'h0);
      req = 3'b010;
      step();
      req = '0;
      repeat (7) step();

      // Write from requester 0
      req_addr[23:0] = 24'h00ABCD;
      req_wdata[31:0] = 32'h5A5A0001;
      pin(0, F_GNT, 32'h1); pin(1, F_LBW, 32'h1); pin(1, F_LBR, 32'h0);
      pin(1, F_ADDR, 32'h00ABCD); pin(1, F_WD, 32'h5A5A0001); pin(2, F_LBW, 32'h0);
      pin(5, F_RDV, 32'h0);
      req = 3'b001; req_we = 3'b001;
      step();
      req = '0; req_we = '0;
      repeat (7) step();

      // Back-to-back read 2, read 0, write 1
      req_addr  = {24'h222222, 24'h000111, 24'h000010};
      req_wdata = {32'h0, 32'h11110001, 32'h0};
      pin(0, F_GNT, 32'h4); pin(1, F_LBR, 32'h1); pin(1, F_ADDR, 32'h222222);
      pin(5, F_RDV, 32'h4); pin(5, F_RDD, 32'hC0222222);
      pin(6, F_RDV, 32'h1); pin(6, F_RDD, 32'hC0000010); pin(7, F_RDV, 32'h0);
      req = 3'b100;
      step();
      pin(0, F_GNT, 32'h1); pin(1, F_LBR, 32'h1); pin(1, F_ADDR, 32'h000010);
      req = 3'b001;
      step();
      pin(0, F_GNT, 32'h2); pin(1, F_LBW, 32'h1); pin(1, F_LBR, 32'h0); pin(1, F_WD, 32'h11110001);
      req = 3'b010; req_we = 3'b010;
      step();
      req = '0; req_we = '0;
      repeat (8) step();

      // Requester 1 withdraws before being served
      pin(0, F_GNT, 32'h1);
      req = 3'b011;
      step();
      pin(0, F_GNT, 32'h0); pin(1, F_LBR, 32'h0); pin(1, F_LBW, 32'h0);
      req = '0;
      repeat (8) step();

      // Reset while a read is in flight
      pin(0, F_GNT, 32'h1);
      req = 3'b001;
      step();
      req = '0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      pin(0, F_GNT, 32'h1); pin(2, F_RDV, 32'h0);
      req = 3'b101;
      step();
      req = '0;
      repeat (8) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
